writeback_unit: RTL and testbench



---
 rtl/wb_pkg.sv | 27 ++
 rtl/wb_load_fifo.sv | 83 ++++++++
 rtl/writeback_unit.sv | 154 +++++++++++++++
 tb/tb_writeback_unit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared constants, types and helpers for the writeback unit.
//   XLEN_DEFAULT - default register write-port data width
//   REG_ADDR_W   - register index width
//   NUM_REGS     - number of architectural integer registers
//   wb_src_e     - arbiter select (which source owns the write port this cycle)
//   reg_onehot   - one-hot decode of a register index with x0 always masked off
package wb_pkg;

  localparam int XLEN_DEFAULT = 64;
  localparam int REG_ADDR_W   = 5;
  localparam int NUM_REGS     = 32;

  typedef enum logic [1:0] {
    WB_SRC_NONE = 2'd0,
    WB_SRC_ALU  = 2'd1,
    WB_SRC_LQ   = 2'd2
  } wb_src_e;

  // x0 is never tracked, so its decode is always zero.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] rd);
    logic [NUM_REGS-1:0] oh;
    oh    = 32'd1 << rd;
    oh[0] = 1'b0;
    return oh;
  endfunction

endpackage

// File: rtl/wb_load_fifo.sv
// wb_load_fifo: small FIFO holding pending load results as {rd, data}.
// Ports:
//   clk, reset_n            - clock, async active-low reset (empties the queue)
//   push_i/push_rd_i/push_data_i - enqueue request (ignored when full)
//   pop_i                   - dequeue head (ignored when empty)
//   head_rd_o/head_data_o   - current head entry (valid when !empty_o)
//   count_o, full_o, empty_o - occupancy status
module wb_load_fifo
  import wb_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int LQ_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      push_i,
  input  logic [REG_ADDR_W-1:0]     push_rd_i,
  input  logic [XLEN-1:0]           push_data_i,
  input  logic                      pop_i,
  output logic [REG_ADDR_W-1:0]     head_rd_o,
  output logic [XLEN-1:0]           head_data_o,
  output logic [$clog2(LQ_DEPTH):0] count_o,
  output logic                      full_o,
  output logic                      empty_o
);

  localparam int PTR_W = $clog2(LQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [REG_ADDR_W-1:0] rd_mem_q   [LQ_DEPTH];
  logic [XLEN-1:0]       data_mem_q [LQ_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  push_ok, pop_ok;

  assign full_o      = (count_q == CNT_W'(LQ_DEPTH));
  assign empty_o     = (count_q == CNT_W'(0));
  assign count_o     = count_q;
  assign head_rd_o   = rd_mem_q[rd_ptr_q];
  assign head_data_o = data_mem_q[rd_ptr_q];

  // Next-state pointers and occupancy; depth is a power of two so pointers wrap naturally.
  always_comb begin
    push_ok  = push_i && !full_o;
    pop_ok   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      rd_mem_q[wr_ptr_q]   <= push_rd_i;
      data_mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: write-side master of the 32 x XLEN integer register file.
// Merges single-cycle ALU results and queued load results onto the single
// register-file write port and keeps a per-register busy scoreboard.
// Ports:
//   clk, reset_n                        - clock, async active-low reset
//   alu_valid/alu_ready/alu_rd/alu_data - ALU result handshake
//   ld_valid/ld_ready/ld_rd/ld_data     - load result handshake (into the queue)
//   issue_valid/issue_rd                - destination of the instruction issued this cycle
//   busy_mask                           - bit i set while a write to xi is pending
//   wb_we/wb_rd/wb_data                 - registered register-file write port
//   lq_count                            - load queue occupancy
// Optional build macro WB_BYPASS_EN adds fwd_valid/fwd_rd/fwd_data, a copy of the
// write port (suppressed for x0) that decode muxes over the register-file read.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int LQ_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      alu_valid,
  output logic                      alu_ready,
  input  logic [REG_ADDR_W-1:0]     alu_rd,
  input  logic [XLEN-1:0]           alu_data,
  input  logic                      ld_valid,
  output logic                      ld_ready,
  input  logic [REG_ADDR_W-1:0]     ld_rd,
  input  logic [XLEN-1:0]           ld_data,
  input  logic                      issue_valid,
  input  logic [REG_ADDR_W-1:0]     issue_rd,
  output logic [NUM_REGS-1:0]       busy_mask,
  output logic                      wb_we,
  output logic [REG_ADDR_W-1:0]     wb_rd,
  output logic [XLEN-1:0]           wb_data,
  output logic [$clog2(LQ_DEPTH):0] lq_count
`ifdef WB_BYPASS_EN
  ,
  output logic                      fwd_valid,
  output logic [REG_ADDR_W-1:0]     fwd_rd,
  output logic [XLEN-1:0]           fwd_data
`endif
);

  logic                  lq_full, lq_empty;
  logic [REG_ADDR_W-1:0] lq_head_rd;
  logic [XLEN-1:0]       lq_head_data;
  logic                  lq_push, lq_pop;

  wb_src_e               win_src;
  logic [REG_ADDR_W-1:0] win_rd;
  logic [XLEN-1:0]       win_data;
  logic                  win_writes;

  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic                  wb_we_q, wb_we_d;
  logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]       wb_data_q, wb_data_d;

  wb_load_fifo #(
    .XLEN     (XLEN),
    .LQ_DEPTH (LQ_DEPTH)
  ) u_lq (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (lq_push),
    .push_rd_i   (ld_rd),
    .push_data_i (ld_data),
    .pop_i       (lq_pop),
    .head_rd_o   (lq_head_rd),
    .head_data_o (lq_head_data),
    .count_o     (lq_count),
    .full_o      (lq_full),
    .empty_o     (lq_empty)
  );

  // A full queue blocks the ALU so loads can never starve; otherwise the ALU has priority.
  assign ld_ready  = !lq_full;
  assign alu_ready = !lq_full;
  assign lq_push   = ld_valid && !lq_full;
  assign lq_pop    = (win_src == WB_SRC_LQ);

  // Arbiter, scoreboard and write-port next state.
  always_comb begin
    win_src = WB_SRC_NONE;
    if (lq_full) begin
      win_src = WB_SRC_LQ;
    end else if (alu_valid) begin
      win_src = WB_SRC_ALU;
    end else if (!lq_empty) begin
      win_src = WB_SRC_LQ;
    end else begin
      win_src = WB_SRC_NONE;
    end

    case (win_src)
      WB_SRC_ALU: begin
        win_rd   = alu_rd;
        win_data = alu_data;
      end
      WB_SRC_LQ: begin
        win_rd   = lq_head_rd;
        win_data = lq_head_data;
      end
      default: begin
        win_rd   = '0;
        win_data = '0;
      end
    endcase

    // Writes to x0 are consumed silently.
    win_writes = (win_src != WB_SRC_NONE) && (win_rd != 5'd0);

    // Clear first, then set, so a same-cycle set of the same register wins.
    busy_d = busy_q & ~(win_writes ? reg_onehot(win_rd) : 32'd0);
    busy_d = busy_d | (issue_valid ? reg_onehot(issue_rd) : 32'd0);

    wb_we_d = win_writes;
    if (win_writes) begin
      wb_rd_d   = win_rd;
      wb_data_d = win_data;
    end else begin
      wb_rd_d   = wb_rd_q;
      wb_data_d = wb_data_q;
    end
  end

  // Scoreboard and registered write port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q    <= '0;
      wb_we_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      busy_q    <= busy_d;
      wb_we_q   <= wb_we_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign busy_mask = busy_q;
  assign wb_we     = wb_we_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;

`ifdef WB_BYPASS_EN
  assign fwd_valid = wb_we_q && (wb_rd_q != 5'd0);
  assign fwd_rd    = wb_rd_q;
  assign fwd_data  = wb_data_q;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios followed by a
// randomized run, all compared against a queue-based behavioural model.
module tb_writeback_unit;

  localparam int XLEN = 64;
  localparam int LQ   = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            alu_valid, alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            ld_valid, ld_ready;
  logic [4:0]      ld_rd;
  logic [XLEN-1:0] ld_data;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic [31:0]     busy_mask;
  logic            wb_we;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic [2:0]      lq_count;
`ifdef WB_BYPASS_EN
  logic            fwd_valid;
  logic [4:0]      fwd_rd;
  logic [XLEN-1:0] fwd_data;
`endif

  always #5 clk = ~clk;

  writeback_unit #(.XLEN(XLEN), .LQ_DEPTH(LQ)) dut (
    .clk(clk), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .busy_mask(busy_mask),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .lq_count(lq_count)
`ifdef WB_BYPASS_EN
    , .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
`endif
  );

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Behavioural model: pending loads in order, busy set, expected write port.
  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ent_t;
  ent_t            mq[$];
  logic [4:0]      pool[$];
  logic [31:0]     m_busy;
  logic            m_we;
  logic [4:0]      m_rd;
  logic [XLEN-1:0] m_data;
  bit              m_alu_acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    pool.delete();
    m_busy = 32'd0;
    m_we   = 1'b0;
    m_rd   = 5'd0;
    m_data = 64'd0;
  endtask

  // One clock: check handshakes, predict, clock, check the results.
  task automatic cycle();
    ent_t w;
    bit   has;
    bit   full_b;
    full_b = (mq.size() == LQ);
    chk("alu_ready", alu_ready, !full_b);
    chk("ld_ready", ld_ready, !full_b);
    has = 1'b0;
    if (full_b) begin
      w = mq.pop_front(); has = 1'b1;
    end else if (alu_valid) begin
      w.rd = alu_rd; w.data = alu_data; has = 1'b1;
    end else if (mq.size() != 0) begin
      w = mq.pop_front(); has = 1'b1;
    end
    m_alu_acc = alu_valid && !full_b;
    if (ld_valid && !full_b) mq.push_back('{ld_rd, ld_data});
    if (has && w.rd != 5'd0) begin
      m_busy[w.rd] = 1'b0;
      m_we = 1'b1; m_rd = w.rd; m_data = w.data;
    end else begin
      m_we = 1'b0;
    end
    if (issue_valid && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
    @(posedge clk); #1;
    chk("wb_we", wb_we, m_we);
    chk("wb_rd", wb_rd, m_rd);
    chk("wb_data", wb_data, m_data);
    chk("busy_mask", busy_mask, m_busy);
    chk("lq_count", lq_count, mq.size());
`ifdef WB_BYPASS_EN
    chk("fwd_valid", fwd_valid, m_we);
    chk("fwd_rd", fwd_rd, m_rd);
    chk("fwd_data", fwd_data, m_data);
`endif
  endtask

  initial begin
    reset_n = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'hF;
    ld_valid = 1'b0; ld_rd = 5'd0; ld_data = 64'd0;
    issue_valid = 1'b0; issue_rd = 5'd0;
    model_reset();

    // Reset held with an ALU result offered: nothing moves.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wb_we", wb_we, 1'b0);
    chk("rst_wb_rd", wb_rd, 5'd0);
    chk("rst_wb_data", wb_data, 64'd0);
    chk("rst_busy", busy_mask, 32'd0);
    chk("rst_lq_count", lq_count, 3'd0);
    reset_n = 1'b1;
    cycle();
    chk("first_we", wb_we, 1'b1);
    chk("first_rd", wb_rd, 5'd5);
    chk("first_data", wb_data, 64'hF);
    alu_valid = 1'b0;

    // Busy tracking of x3 across three cycles, cleared on acceptance.
    issue_valid = 1'b1; issue_rd = 5'd3;
    cycle();
    issue_valid = 1'b0;
    chk("busy3_c1", busy_mask[3], 1'b1);
    cycle();
    chk("busy3_c2", busy_mask[3], 1'b1);
    cycle();
    chk("busy3_c3", busy_mask[3], 1'b1);
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'h33;
    cycle();
    chk("busy3_clr", busy_mask[3], 1'b0);
    chk("busy3_we", wb_we, 1'b1);
    alu_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd0;
    cycle();
    issue_valid = 1'b0;
    chk("issue_x0", busy_mask, 32'd0);

    // Same-cycle ALU and load into an empty queue.
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 64'd10;
    ld_valid = 1'b1; ld_rd = 5'd2; ld_data = 64'd1765;
    cycle();
    alu_valid = 1'b0; ld_valid = 1'b0;
    chk("same_rd1", wb_rd, 5'd1);
    chk("same_data1", wb_data, 64'd10);
    chk("same_cnt1", lq_count, 3'd1);
    cycle();
    chk("same_we2", wb_we, 1'b1);
    chk("same_rd2", wb_rd, 5'd2);
    chk("same_data2", wb_data, 64'd1765);
    chk("same_cnt2", lq_count, 3'd0);

    // Fill the queue under continuous ALU traffic.
    alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 64'h66;
    ld_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ld_rd = 5'(7 + i); ld_data = 64'(100 + i);
      cycle();
    end
    ld_valid = 1'b0;
    chk("fill_cnt", lq_count, 3'd4);
    chk("fill_ld_ready", ld_ready, 1'b0);
    chk("fill_alu_ready", alu_ready, 1'b0);
    cycle();
    chk("drain_rd", wb_rd, 5'd7);
    chk("drain_data", wb_data, 64'd100);
    chk("drain_cnt", lq_count, 3'd3);
    chk("drain_alu_ready", alu_ready, 1'b1);
    repeat (2) cycle();
    alu_valid = 1'b0;
    repeat (3) cycle();
    chk("drained", lq_count, 3'd0);

    // Write to x0 is consumed without effect.
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'd281;
    cycle();
    alu_valid = 1'b0;
    chk("x0_we", wb_we, 1'b0);
    chk("x0_busy", busy_mask, 32'd0);

    // Asynchronous reset with two queued loads and a busy register.
    issue_valid = 1'b1; issue_rd = 5'd20;
    alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 64'h11;
    ld_valid = 1'b1; ld_rd = 5'd12; ld_data = 64'h12;
    cycle();
    issue_valid = 1'b0;
    ld_rd = 5'd13; ld_data = 64'h13;
    cycle();
    alu_valid = 1'b0; ld_valid = 1'b0;
    chk("pre_rst_cnt", lq_count, 3'd2);
    chk("pre_rst_busy20", busy_mask[20], 1'b1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_cnt", lq_count, 3'd0);
    chk("mid_rst_busy", busy_mask, 32'd0);
    chk("mid_rst_we", wb_we, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_reset();

    // Write to x4; forwarding outputs mirror it when present.
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 64'd281;
    cycle();
    alu_valid = 1'b0;
    chk("x4_we", wb_we, 1'b1);
`ifdef WB_BYPASS_EN
    chk("fwd_x4_valid", fwd_valid, 1'b1);
    chk("fwd_x4_rd", fwd_rd, 5'd4);
    chk("fwd_x4_data", fwd_data, 64'd281);
`endif

    // Randomized traffic: writes only target registers issued earlier.
    for (int n = 0; n < 400; n++) begin
      if (!(alu_valid && !m_alu_acc)) begin
        alu_valid = ($urandom_range(0, 99) < 70);
        alu_rd = 5'd0;
        if (alu_valid && pool.size() != 0 && $urandom_range(0, 3) != 0) alu_rd = pool.pop_front();
        alu_data = {$urandom, $urandom};
      end
      if (!(ld_valid && mq.size() == LQ)) begin
        ld_valid = ($urandom_range(0, 99) < 50);
        ld_rd = 5'd0;
        if (ld_valid && pool.size() != 0 && $urandom_range(0, 3) != 0) ld_rd = pool.pop_front();
        ld_data = {$urandom, $urandom};
      end
      issue_valid = 1'b0;
      if ($urandom_range(0, 99) < 40) begin
        issue_rd = 5'($urandom_range(1, 31));
        if (!m_busy[issue_rd]) issue_valid = 1'b1;
      end
      cycle();
      if (issue_valid) pool.push_back(issue_rd);
    end
    alu_valid = 1'b0; ld_valid = 1'b0; issue_valid = 1'b0;
    repeat (6) cycle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
